// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the single register-file write port, plus per-register pending scoreboard.
// Grant is combinational, the write port is registered one cycle later; grants are never refused, so there is no backpressure.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [NREQ-1:0]      I_req_valid,
  input  logic [NREQ*AW-1:0]   I_req_rd,
  input  logic [NREQ*DW-1:0]   I_req_data,
  output logic [NREQ-1:0]      O_req_ready,
  input  logic                 I_alloc_valid,
  input  logic [AW-1:0]        I_alloc_rd,
  output logic                 O_alloc_ready,
  output logic [(1<<AW)-1:0]   O_pending,
  output logic                 O_regwen,
  output logic [AW-1:0]        O_rd,
  output logic [DW-1:0]        O_data,
  output logic                 O_stray
);

  localparam int NREG = 1 << AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_q, rr_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic            wen_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   data_q;
  logic            stray_q;

  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_data;
  logic            gnt_wr;
  logic [NREG-1:0] set_v, clr_v;

  // Search order starts at rr_q and wraps; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    if (!I_rst) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_any && (((int'(rr_q) + k) % NREQ) == i) && I_req_valid[i]) begin
            gnt_any = 1'b1;
            gnt[i]  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    rr_d     = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_rd   = I_req_rd[i*AW +: AW];
        gnt_data = I_req_data[i*DW +: DW];
        rr_d     = PW'((i + 1) % NREQ);
      end
    end
  end

  assign gnt_wr        = gnt_any && (gnt_rd != '0);
  assign O_alloc_ready = !pend_q[I_alloc_rd];

  // A clear and a set of the same register cannot coincide on a legal alloc, so set simply wins.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (I_alloc_valid && O_alloc_ready && (I_alloc_rd != '0)) set_v[I_alloc_rd] = 1'b1;
    if (gnt_wr) clr_v[gnt_rd] = 1'b1;
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rr_q    <= '0;
      pend_q  <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      wen_q   <= gnt_wr;
      stray_q <= gnt_wr && !pend_q[gnt_rd];
      if (gnt_any) begin
        rd_q   <= gnt_rd;
        data_q <= gnt_data;
      end
    end
  end

  assign O_req_ready = gnt;
  assign O_pending   = pend_q;
  assign O_regwen    = wen_q;
  assign O_rd        = rd_q;
  assign O_data      = data_q;
  assign O_stray     = stray_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        alloc_valid;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [15:0] pending;
  logic        regwen;
  logic [3:0]  rd;
  logic [31:0] data;
  logic        stray;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(3), .DW(32), .AW(4)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_req_valid(req_valid), .I_req_rd(req_rd), .I_req_data(req_data),
    .O_req_ready(req_ready),
    .I_alloc_valid(alloc_valid), .I_alloc_rd(alloc_rd), .O_alloc_ready(alloc_ready),
    .O_pending(pending), .O_regwen(regwen), .O_rd(rd), .O_data(data), .O_stray(stray)
  );

  typedef struct {
    logic [2:0]  vld;
    logic [3:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic        av;
    logic [3:0]  ard;
    logic [2:0]  e_rdy;
    logic        e_ardy;
    logic        e_wen;
    logic [3:0]  e_rd;
    logic [31:0] e_data;
    logic        e_stray;
    logic [15:0] e_pend;
  } vec_t;

  function automatic vec_t mk(logic [2:0] vld,
                              logic [3:0] rd0, logic [31:0] d0,
                              logic [3:0] rd1, logic [31:0] d1,
                              logic [3:0] rd2, logic [31:0] d2,
                              logic av, logic [3:0] ard,
                              logic [2:0] e_rdy, logic e_ardy, logic e_wen,
                              logic [3:0] e_rd, logic [31:0] e_data,
                              logic e_stray, logic [15:0] e_pend);
    vec_t v;
    v.vld = vld; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1; v.rd2 = rd2; v.d2 = d2;
    v.av = av; v.ard = ard; v.e_rdy = e_rdy; v.e_ardy = e_ardy; v.e_wen = e_wen;
    v.e_rd = e_rd; v.e_data = e_data; v.e_stray = e_stray; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(int i, logic v, logic [3:0] r, logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*4 +: 4]   = r;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic apply(vec_t v, int n);
    set_req(0, v.vld[0], v.rd0, v.d0);
    set_req(1, v.vld[1], v.rd1, v.d1);
    set_req(2, v.vld[2], v.rd2, v.d2);
    alloc_valid = v.av;
    alloc_rd    = v.ard;
    @(negedge clk);
    chk($sformatf("v%0d.ready", n), 32'(req_ready), 32'(v.e_rdy));
    chk($sformatf("v%0d.alloc_ready", n), 32'(alloc_ready), 32'(v.e_ardy));
    @(posedge clk); #1;
    chk($sformatf("v%0d.regwen", n), 32'(regwen), 32'(v.e_wen));
    chk($sformatf("v%0d.rd", n), 32'(rd), 32'(v.e_rd));
    chk($sformatf("v%0d.data", n), data, v.e_data);
    chk($sformatf("v%0d.stray", n), 32'(stray), 32'(v.e_stray));
    chk($sformatf("v%0d.pending", n), 32'(pending), 32'(v.e_pend));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0;

    //      vld     rd0 d0          rd1 d1            rd2 d2          av ard  rdy    ardy wen rd  data          st  pend
    tbl[0]  = mk(3'b000, 0, 0,       0, 0,            0, 0,        0, 0,  3'b000, 1, 0, 0, 32'h0,        0, 16'h0000);
    tbl[1]  = mk(3'b000, 0, 0,       0, 0,            0, 0,        1, 5,  3'b000, 1, 0, 0, 32'h0,        0, 16'h0020);
    tbl[2]  = mk(3'b000, 0, 0,       0, 0,            0, 0,        1, 7,  3'b000, 1, 0, 0, 32'h0,        0, 16'h00A0);
    tbl[3]  = mk(3'b000, 0, 0,       0, 0,            0, 0,        1, 5,  3'b000, 0, 0, 0, 32'h0,        0, 16'h00A0);
    tbl[4]  = mk(3'b010, 0, 0,       5, 32'hDEADBEEF, 0, 0,        1, 5,  3'b010, 0, 1, 5, 32'hDEADBEEF, 0, 16'h0080);
    tbl[5]  = mk(3'b000, 0, 0,       0, 0,            0, 0,        1, 5,  3'b000, 1, 0, 5, 32'hDEADBEEF, 0, 16'h00A0);
    tbl[6]  = mk(3'b111, 7, 32'h1111, 0, 32'h2222,    9, 32'h3333, 0, 0,  3'b100, 1, 1, 9, 32'h3333,     1, 16'h00A0);
    tbl[7]  = mk(3'b011, 7, 32'h1111, 0, 32'h2222,    0, 0,        0, 0,  3'b001, 1, 1, 7, 32'h1111,     0, 16'h0020);
    tbl[8]  = mk(3'b010, 0, 0,       0, 32'h12345678, 0, 0,        1, 3,  3'b010, 1, 0, 0, 32'h12345678, 0, 16'h0028);
    tbl[9]  = mk(3'b001, 5, 32'h5555, 0, 0,            0, 0,        1, 12, 3'b001, 1, 1, 5, 32'h5555,     0, 16'h1008);
    tbl[10] = mk(3'b000, 0, 0,       0, 0,            0, 0,        0, 0,  3'b000, 1, 0, 5, 32'h5555,     0, 16'h1008);

    req_valid = 3'b111;
    do_reset();
    req_valid = '0;
    for (int i = 0; i < 11; i++) apply(tbl[i], i);

    // Round robin from a fresh reset: pointer was left at 1 by the table.
    set_req(0, 1, 1, 32'hA0); set_req(1, 1, 2, 32'hA1); set_req(2, 1, 3, 32'hA2);
    do_reset();
    chk("rst.regwen", 32'(regwen), 32'h0);
    chk("rst.rd", 32'(rd), 32'h0);
    chk("rst.data", data, 32'h0);
    chk("rst.stray", 32'(stray), 32'h0);
    chk("rst.pending", 32'(pending), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(1 << (k % 3)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d.regwen", k), 32'(regwen), 32'h1);
      chk($sformatf("rr%0d.rd", k), 32'(rd), 32'(k % 3 + 1));
      chk($sformatf("rr%0d.data", k), data, 32'hA0 + 32'(k % 3));
    end
    req_valid = '0;

    // Allocation of x7 blocked until its write-back is granted.
    alloc_valid = 1'b1; alloc_rd = 4'd7;
    @(posedge clk); #1;
    chk("b.pend_set", 32'(pending), 32'h0080);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("b.stall%0d", k), 32'(alloc_ready), 32'h0);
      @(posedge clk); #1;
    end
    set_req(1, 1, 7, 32'h77);
    @(negedge clk);
    chk("b.grant_ready", 32'(req_ready), 32'h2);
    chk("b.grant_ardy", 32'(alloc_ready), 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("b.realloc_ardy", 32'(alloc_ready), 32'h1);
    chk("b.realloc_wen", 32'(regwen), 32'h1);
    chk("b.realloc_stray", 32'(stray), 32'h0);
    @(posedge clk); #1;
    chk("b.realloc_pend", 32'(pending), 32'h0080);

    // Reset in mid-operation drops a presented request.
    alloc_rd = 4'd3;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
    chk("c.pend", 32'(pending), 32'h0088);
    set_req(0, 1, 4, 32'h44);
    @(negedge clk);
    chk("c.pre_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0);
    set_req(2, 1, 3, 32'h33);
    rst = 1'b1;
    @(negedge clk);
    chk("c.rst_ready", 32'(req_ready), 32'h0);
    chk("c.rst_wen_before", 32'(regwen), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("c.post_wen", 32'(regwen), 32'h0);
    chk("c.post_pend", 32'(pending), 32'h0);
    chk("c.post_stray", 32'(stray), 32'h0);
    @(negedge clk);
    chk("c.represent_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    chk("c.represent_wen", 32'(regwen), 32'h1);
    chk("c.represent_rd", 32'(rd), 32'h3);
    chk("c.represent_data", data, 32'h33);
    chk("c.represent_stray", 32'(stray), 32'h1);
    @(posedge clk); #1;
    chk("c.stray_drop", 32'(stray), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 16-entry, single-write-port register file of the RV32E-style CPU. It grants up to NREQ write-back sources (ALU, load unit, CSR unit) onto the one write port in round-robin order and drives the register file's regwen/rd/data from a registered output stage. It also keeps a per-register pending bit, set at issue and cleared at write-back, which the issue logic uses for RAW and WAW stalls.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..4)
- DW, 32, data width
- AW, 4, register index width (16 registers, x0 hardwired zero)

Ports:
- I_clk  in  1  clock; all state updates on rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_req_valid  in  NREQ  requester i has a write-back pending
- I_req_rd  in  NREQ*AW  destination index, requester i in bits [i*AW +: AW]
- I_req_data  in  NREQ*DW  write data, requester i in bits [i*DW +: DW]
- O_req_ready  out  NREQ  one-hot grant; transfer i occurs when valid[i] && ready[i]
- I_alloc_valid  in  1  issue logic allocating a destination register
- I_alloc_rd  in  AW  register being allocated
- O_alloc_ready  out  1  allocation accepted this cycle
- O_pending  out  16  bit r = write to xr outstanding; bit 0 always 0
- O_regwen  out  1  register-file write enable
- O_rd  out  AW  register-file write index
- O_data  out  DW  register-file write data
- O_stray  out  1  one-cycle pulse: granted write to a non-pending, non-zero register

## Operation
- Arbitration is combinational. Each cycle with any valid request, exactly one requester is granted. Search starts at rr_ptr and wraps modulo NREQ; the first valid index wins.
- After a grant to index g, rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- O_req_ready is zero when no request is valid, and zero throughout any cycle with I_rst=1.
- A grant is never refused. The output stage accepts one write per cycle, so no backpressure reaches the register file.
- Output stage, at the edge ending the grant cycle:
  - O_rd <= rd[g], O_data <= data[g]
  - O_regwen <= (rd[g] != 0)
  - With no grant, O_regwen <= 0; O_rd and O_data hold.
- Writes to x0 are consumed: ready is asserted, O_regwen stays 0, pending is unchanged, O_stray is not raised.
- Scoreboard:
  - O_alloc_ready = !pending[I_alloc_rd], evaluated combinationally on registered state. It is always 1 for rd=0.
  - Accepted allocation (valid && ready, rd != 0) sets pending[rd] at the edge.
  - Granted write to rd != 0 clears pending[rd] at the edge.
  - Same-cycle clear and allocate of the same rd cannot occur, because alloc_ready is low while pending=1; there is no bypass.
  - Same-cycle clear of ra and set of rb with ra != rb: both take effect.
- Stray write: a granted rd != 0 with pending[rd]=0 is still written to the register file and raises O_stray for one cycle, aligned with O_regwen.
- Reset values: O_regwen=0, O_rd=0, O_data=0, O_stray=0, O_pending=0, rr_ptr=0.
- Reset mid-operation: any request presented during the reset cycle is not granted and is lost. The requester must re-present it after reset.

## Timing
- Grant in cycle t, O_regwen/O_rd/O_data valid in cycle t+1, register file updated at the edge ending t+1. A register-file read returns the new value from cycle t+2.
- pending[rd] reads 0 from cycle t+1, the same cycle O_regwen is high. A re-allocation of rd is accepted in cycle t+1 at the earliest.
- Sustained throughput is one write per cycle. With all NREQ valid continuously, each requester is granted exactly once every NREQ cycles.
- Requesters hold valid, rd and data stable until ready. Deasserting valid before ready is legal and drops the request.

## Test plan
- Reset, then alloc x5 in cycle 1, then requester 1 presents rd=5, data=0xDEADBEEF in cycle 3:
  - ready[1] is high in cycle 3.
  - Cycle 4: O_regwen=1, O_rd=5, O_data=0xDEADBEEF.
  - O_pending[5] is high in cycles 2-3 and low from cycle 4.
- All three requesters held valid for 6 cycles, rr_ptr=0 after reset: grant order 0,1,2,0,1,2 with one O_regwen pulse per cycle.
- x7 pending, alloc x7: O_alloc_ready=0 each cycle until the x7 write is granted; alloc accepted in the following cycle.
- Write to rd=0 with data 0x12345678: ready asserted, O_regwen=0 next cycle, O_pending stays 0, O_stray=0.
- Granted write to rd=9 with pending[9]=0: O_regwen=1 and O_stray=1 for exactly one cycle.
- Requester 2 valid (rd=3) while I_rst=1 with x3 allocated before reset:
  - ready=0 during reset.
  - Cycle after reset: O_regwen=0, O_pending=0, rr_ptr=0.
  - Requester 2 re-presents and is granted on its first valid cycle.
